// File: rtl/config_loader_if.sv
// Host-stream plus tile-chain signal bundle for config_loader.
// The loader side uses the slave modport. The host or testbench side uses the master modport.
interface config_loader_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 11
);
    logic              start;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              cfg_cen;
    logic              cfg_shift;
    logic              cfg_set;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bits_sent;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, cfg_cen, cfg_shift, cfg_set, busy, done, bits_sent
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, cfg_cen, cfg_shift, cfg_set, busy, done, bits_sent
    );
endinterface

// File: rtl/config_loader.sv
// Serialises host configuration words MSB-first into a tile chain of CHAIN_LEN bits.
// After the last bit it issues one latch strobe, then one completion pulse.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    config_loader_if.slave bus
);
    localparam int               WCNT_W   = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SET, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] shreg;
    logic [WCNT_W-1:0] word_cnt;
    logic [CNT_W-1:0]  bit_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next is defaulted before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start)    state_next = LOAD;
            LOAD:    if (bus.in_valid) state_next = SHIFT;
            SHIFT: begin
                // The chain end takes priority, so surplus bits of the final word are dropped.
                if (bit_cnt == LAST_BIT)              state_next = SET;
                else if (word_cnt == WCNT_W'(1))      state_next = LOAD;
            end
            SET:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            word_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) bit_cnt <= '0;
                LOAD: begin
                    if (bus.in_valid) begin
                        shreg    <= bus.in_data;
                        word_cnt <= WCNT_W'(WORD_W);
                    end
                end
                SHIFT: begin
                    shreg    <= shreg << 1;
                    word_cnt <= word_cnt - WCNT_W'(1);
                    if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore outputs: each one decodes from the state register or from datapath registers only.
    assign bus.in_ready  = (state == LOAD);
    assign bus.cfg_cen   = (state == SHIFT);
    assign bus.cfg_shift = (state == SHIFT) & shreg[WORD_W-1];
    assign bus.cfg_set   = (state == SET);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.bits_sent = bit_cnt;
endmodule
